// File: rtl/register_alarm_clock_pkg.sv
// rtl/register_alarm_clock_pkg.sv - shared BCD time types and limits for the alarm-clock subsystem
package register_alarm_clock_pkg;

  typedef logic [3:0] bcd_t;

  localparam bcd_t MAX_MS_MIN      = 4'd5;
  localparam bcd_t MAX_DIGIT       = 4'd9;
  localparam bcd_t MAX_MS_HR       = 4'd1;
  localparam bcd_t MAX_LS_HR_TEENS = 4'd2;

  // 17-bit alarm time, shared with the comparator and display paths
  typedef struct packed {
    bcd_t ms_hr;
    bcd_t ls_hr;
    bcd_t ms_min;
    bcd_t ls_min;
    logic am;
  } alarm_time_t;

endpackage

// File: rtl/register_alarm_clock_bcd_time_validator.sv
// rtl/register_alarm_clock_bcd_time_validator.sv - combinational 12-hour BCD time check (01:00..12:59)
module bcd_time_validator
  import register_alarm_clock_pkg::*;
(
  input  bcd_t i_ms_hr,
  input  bcd_t i_ls_hr,
  input  bcd_t i_ms_min,
  input  bcd_t i_ls_min,
  output logic o_valid
);

  logic w_min_ok;
  logic w_hr_single;
  logic w_hr_teens;

  assign w_min_ok    = (i_ms_min <= MAX_MS_MIN) && (i_ls_min <= MAX_DIGIT);
  // Hours 01..09 need a non-zero units digit; 10..12 cap the units digit at 2
  assign w_hr_single = (i_ms_hr == 4'd0) && (i_ls_hr != 4'd0) && (i_ls_hr <= MAX_DIGIT);
  assign w_hr_teens  = (i_ms_hr == MAX_MS_HR) && (i_ls_hr <= MAX_LS_HR_TEENS);
  assign o_valid     = w_min_ok && (w_hr_single || w_hr_teens);

endmodule

// File: rtl/register_alarm_clock.sv
// rtl/register_alarm_clock.sv - alarm time register with validated atomic load and reject pulse
module register_alarm_clock
  import register_alarm_clock_pkg::*;
#(
  parameter logic [3:0] RST_MS_HR  = 4'd1,
  parameter logic [3:0] RST_LS_HR  = 4'd2,
  parameter logic [3:0] RST_MS_MIN = 4'd0,
  parameter logic [3:0] RST_LS_MIN = 4'd0,
  parameter logic       RST_AM     = 1'b1
) (
  input  logic       clock,
  input  logic       reset_a,
  input  logic [3:0] new_current_alarm_ls_min,
  input  logic [3:0] new_current_alarm_ms_min,
  input  logic [3:0] new_current_alarm_ls_hr,
  input  logic [3:0] new_current_alarm_ms_hr,
  input  logic       new_current_alarm_am,
  input  logic       load_new_a,
  output logic [3:0] current_alarm_ls_min,
  output logic [3:0] current_alarm_ms_min,
  output logic [3:0] current_alarm_ls_hr,
  output logic [3:0] current_alarm_ms_hr,
  output logic       current_alarm_am,
  output logic       load_err
);

  alarm_time_t w_cand;
  alarm_time_t r_alarm;
  logic        w_valid;
  logic        r_load_err;

  assign w_cand = '{ms_hr:  new_current_alarm_ms_hr,
                    ls_hr:  new_current_alarm_ls_hr,
                    ms_min: new_current_alarm_ms_min,
                    ls_min: new_current_alarm_ls_min,
                    am:     new_current_alarm_am};

  bcd_time_validator u_validator (
    .i_ms_hr  (w_cand.ms_hr),
    .i_ls_hr  (w_cand.ls_hr),
    .i_ms_min (w_cand.ms_min),
    .i_ls_min (w_cand.ls_min),
    .o_valid  (w_valid)
  );

  // All five fields move in one register write so downstream never sees a torn time
  always_ff @(posedge clock or negedge reset_a) begin
    if (!reset_a) begin
      r_alarm    <= '{ms_hr: RST_MS_HR, ls_hr: RST_LS_HR, ms_min: RST_MS_MIN,
                      ls_min: RST_LS_MIN, am: RST_AM};
      r_load_err <= 1'b0;
    end else begin
      r_load_err <= load_new_a && !w_valid;
      if (load_new_a && w_valid) begin
        r_alarm <= w_cand;
      end
    end
  end

  assign current_alarm_ms_hr  = r_alarm.ms_hr;
  assign current_alarm_ls_hr  = r_alarm.ls_hr;
  assign current_alarm_ms_min = r_alarm.ms_min;
  assign current_alarm_ls_min = r_alarm.ls_min;
  assign current_alarm_am     = r_alarm.am;
  assign load_err             = r_load_err;

endmodule

// File: tb/tb_register_alarm_clock.sv
// tb/tb_register_alarm_clock.sv - self-checking bench for register_alarm_clock
module tb_register_alarm_clock;

  logic       clock;
  logic       reset_a;
  logic [3:0] in_ls_min, in_ms_min, in_ls_hr, in_ms_hr;
  logic       in_am;
  logic       load_new_a;
  logic [3:0] out_ls_min, out_ms_min, out_ls_hr, out_ms_hr;
  logic       out_am;
  logic       load_err;

  int checks = 0;
  int errors = 0;

  // Reference state: held time and the error flag expected after the latest edge
  logic [3:0] m_h1, m_h0, m_m1, m_m0;
  logic       m_am, m_err;

  localparam logic [17:0] RST_OBS = {4'd1, 4'd2, 4'd0, 4'd0, 1'b1, 1'b0};

  logic [17:0] obs;
  assign obs = {out_ms_hr, out_ls_hr, out_ms_min, out_ls_min, out_am, load_err};

  register_alarm_clock dut (
    .clock                    (clock),
    .reset_a                  (reset_a),
    .new_current_alarm_ls_min (in_ls_min),
    .new_current_alarm_ms_min (in_ms_min),
    .new_current_alarm_ls_hr  (in_ls_hr),
    .new_current_alarm_ms_hr  (in_ms_hr),
    .new_current_alarm_am     (in_am),
    .load_new_a               (load_new_a),
    .current_alarm_ls_min     (out_ls_min),
    .current_alarm_ms_min     (out_ms_min),
    .current_alarm_ls_hr      (out_ls_hr),
    .current_alarm_ms_hr      (out_ms_hr),
    .current_alarm_am         (out_am),
    .load_err                 (load_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // A 12-hour time: every digit a decimal digit, hour 1..12, minute 0..59
  function automatic bit ref_valid(int h1, int h0, int m1, int m0);
    int hour, minute;
    hour   = h1 * 10 + h0;
    minute = m1 * 10 + m0;
    return (h1 <= 9) && (h0 <= 9) && (m1 <= 9) && (m0 <= 9) &&
           (hour >= 1) && (hour <= 12) && (minute <= 59);
  endfunction

  function automatic logic [17:0] exp_obs();
    return {m_h1, m_h0, m_m1, m_m0, m_am, m_err};
  endfunction

  task automatic model_reset();
    m_h1 = 4'd1; m_h0 = 4'd2; m_m1 = 4'd0; m_m0 = 4'd0; m_am = 1'b1; m_err = 1'b0;
  endtask

  task automatic set_inputs(int h1, int h0, int m1, int m0, bit am, bit load);
    in_ms_hr = h1[3:0]; in_ls_hr = h0[3:0]; in_ms_min = m1[3:0]; in_ls_min = m0[3:0];
    in_am = am; load_new_a = load;
  endtask

  task automatic assert_reset();
    reset_a = 1'b0;
    model_reset();
  endtask

  // One rising edge: model samples the inputs present at the edge, then step off the edge
  task automatic tick();
    @(posedge clock);
    if (reset_a) begin
      if (load_new_a) begin
        if (ref_valid(in_ms_hr, in_ls_hr, in_ms_min, in_ls_min)) begin
          m_h1 = in_ms_hr; m_h0 = in_ls_hr; m_m1 = in_ms_min; m_m0 = in_ls_min;
          m_am = in_am; m_err = 1'b0;
        end else begin
          m_err = 1'b1;
        end
      end else begin
        m_err = 1'b0;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    set_inputs(0, 7, 1, 5, 0, 0);
    reset_a = 1'b1;
    #2;
    assert_reset();
    #1;
    if (obs !== RST_OBS) begin errors++; $display("FAIL reset_immediate: got %h expected %h", obs, RST_OBS); end
    checks++;
    set_inputs(0, 5, 3, 0, 0, 1);
    tick(); tick();
    if (obs !== RST_OBS) begin errors++; $display("FAIL reset_hold: got %h expected %h", obs, RST_OBS); end
    checks++;
    load_new_a = 1'b0;
    #3;
    reset_a = 1'b1;
    tick();
    if (obs !== exp_obs()) begin errors++; $display("FAIL reset_release: got %h expected %h", obs, exp_obs()); end
    checks++;
  endtask

  task automatic test_load_1242();
    set_inputs(1, 2, 4, 2, 1, 1);
    tick();
    if (obs !== {4'd1, 4'd2, 4'd4, 4'd2, 1'b1, 1'b0}) begin
      errors++; $display("FAIL load_1242: got %h expected %h", obs, {4'd1, 4'd2, 4'd4, 4'd2, 1'b1, 1'b0});
    end
    checks++;
    load_new_a = 1'b0;
    tick();
    if (obs !== exp_obs()) begin errors++; $display("FAIL load_1242_hold: got %h expected %h", obs, exp_obs()); end
    checks++;
  endtask

  task automatic test_inputs_ignored();
    set_inputs(0, 7, 1, 5, 0, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      if (obs !== {4'd1, 4'd2, 4'd4, 4'd2, 1'b1, 1'b0}) begin
        errors++; $display("FAIL no_load_hold cycle %0d: got %h expected %h", i, obs, {4'd1, 4'd2, 4'd4, 4'd2, 1'b1, 1'b0});
      end
      checks++;
    end
  endtask

  task automatic test_reject();
    set_inputs(1, 3, 0, 0, 0, 1);
    tick();
    if (obs !== {4'd1, 4'd2, 4'd4, 4'd2, 1'b1, 1'b1}) begin
      errors++; $display("FAIL reject_1300: got %h expected %h", obs, {4'd1, 4'd2, 4'd4, 4'd2, 1'b1, 1'b1});
    end
    checks++;
    load_new_a = 1'b0;
    tick();
    if (obs !== exp_obs()) begin errors++; $display("FAIL reject_err_clears: got %h expected %h", obs, exp_obs()); end
    checks++;
    set_inputs(0, 9, 6, 0, 1, 1);
    tick();
    if (obs !== {4'd1, 4'd2, 4'd4, 4'd2, 1'b1, 1'b1}) begin
      errors++; $display("FAIL reject_0960: got %h expected %h", obs, {4'd1, 4'd2, 4'd4, 4'd2, 1'b1, 1'b1});
    end
    checks++;
    load_new_a = 1'b0;
    tick();
    if (obs !== exp_obs()) begin errors++; $display("FAIL reject_err_clears2: got %h expected %h", obs, exp_obs()); end
    checks++;
  endtask

  task automatic test_track();
    set_inputs(0, 1, 0, 0, 1, 1);
    tick();
    if (obs !== {4'd0, 4'd1, 4'd0, 4'd0, 1'b1, 1'b0}) begin
      errors++; $display("FAIL track_0100: got %h expected %h", obs, {4'd0, 4'd1, 4'd0, 4'd0, 1'b1, 1'b0});
    end
    checks++;
    set_inputs(1, 1, 5, 9, 1, 1);
    tick();
    if (obs !== {4'd1, 4'd1, 4'd5, 4'd9, 1'b1, 1'b0}) begin
      errors++; $display("FAIL track_1159: got %h expected %h", obs, {4'd1, 4'd1, 4'd5, 4'd9, 1'b1, 1'b0});
    end
    checks++;
    set_inputs(1, 2, 0, 0, 0, 1);
    tick();
    if (obs !== {4'd1, 4'd2, 4'd0, 4'd0, 1'b0, 1'b0}) begin
      errors++; $display("FAIL track_1200pm: got %h expected %h", obs, {4'd1, 4'd2, 4'd0, 4'd0, 1'b0, 1'b0});
    end
    checks++;
    load_new_a = 1'b0;
    tick();
  endtask

  task automatic test_reset_with_load();
    set_inputs(0, 5, 3, 0, 0, 1);
    #3;
    assert_reset();
    tick();
    if (obs !== RST_OBS) begin errors++; $display("FAIL reset_beats_load: got %h expected %h", obs, RST_OBS); end
    checks++;
    #3;
    load_new_a = 1'b0;
    reset_a = 1'b1;
    tick();
    if (obs !== exp_obs()) begin errors++; $display("FAIL reset_beats_load_after: got %h expected %h", obs, exp_obs()); end
    checks++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      set_inputs($urandom_range(0, 2), $urandom_range(0, 10), $urandom_range(0, 6),
                 $urandom_range(0, 10), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 39) == 0) begin
        #3;
        assert_reset();
        #1;
        if (obs !== exp_obs()) begin errors++; $display("FAIL random_async_reset %0d: got %h expected %h", i, obs, exp_obs()); end
        checks++;
        #1;
        reset_a = 1'b1;
      end
      tick();
      if (obs !== exp_obs()) begin errors++; $display("FAIL random_step %0d: got %h expected %h", i, obs, exp_obs()); end
      checks++;
    end
  endtask

  initial begin
    test_reset();
    test_load_1242();
    test_inputs_ignored();
    test_reject();
    test_track();
    test_reset_with_load();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
